// File: rtl/channel_pkg.sv
// Shared types and constants for the channel emulator: interrupt FSM states
// and the 16-bit error-injection LFSR seed/taps.
package channel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_BLOCK = 2'd2
  } int_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/channel_lfsr.sv
// Seedable 16-bit Fibonacci LFSR with advance enable and synchronous seed load.
import channel_pkg::*;

module channel_lfsr #(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed_i;
    end else if (en) begin
      lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/channel_emulator.sv
// Line-channel impairment model: per-lane delay line, periodic/forced interrupts
// and optional random bit flips (enabled by defining CHANNEL_ERR_INJECT_EN).
import channel_pkg::*;

module channel_emulator #(
  parameter int   LANES       = 1,
  parameter int   DELAY_DEPTH = 16,
  parameter int   CNT_W       = 20,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic             channel_clk,
  input  logic             channel_rst,
  input  logic [LANES-1:0] data_i,
  input  logic [7:0]       delay_sel,
  input  logic             int_en,
  input  logic [CNT_W-1:0] int_period,
  input  logic [CNT_W-1:0] int_len,
  input  logic             channel_interrupt,
  input  logic [15:0]      ber_thresh,
  output logic [LANES-1:0] data_o,
  output logic             int_active,
  output logic [15:0]      err_count
);

  localparam int             DL_N      = DELAY_DEPTH - 1;
  localparam int             MAX_TAP   = DELAY_DEPTH - 1;
  localparam logic [LANES-1:0] IDLE_WORD = {LANES{IDLE_LEVEL}};

  // The registered output is the last delay stage, so the shift register
  // itself holds DELAY_DEPTH-1 stages ahead of it.
  logic [LANES-1:0] dl_q [DL_N];
  logic [LANES-1:0] dl_d [DL_N];
  logic [LANES-1:0] taps [DELAY_DEPTH];
  logic [LANES-1:0] tapped;
  logic [7:0]       tap_idx;

  logic [LANES-1:0] data_o_q, data_o_d;
  logic             int_active_q, int_active_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  int_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shp_q, shp_d;
  logic [CNT_W-1:0] shl_q, shl_d;
  logic [CNT_W-1:0] eff_period;
  logic [CNT_W-1:0] pass_last;
  logic [CNT_W-1:0] period_last;

  logic blocked;
  logic flip;

  function automatic int_state_e start_state(input logic [CNT_W-1:0] p,
                                             input logic [CNT_W-1:0] l);
    logic [CNT_W-1:0] eff;
    eff = (p == '0) ? CNT_W'(1) : p;
    return (l >= eff) ? ST_BLOCK : ST_PASS;
  endfunction

  always_comb begin
    for (int k = 0; k < DL_N; k++) begin
      dl_d[k] = (k == 0) ? data_i : dl_q[(k == 0) ? 0 : k - 1];
    end
    taps[0] = data_i;
    for (int k = 1; k < DELAY_DEPTH; k++) begin
      taps[k] = dl_q[k-1];
    end
  end

  always_comb begin
    tap_idx = (int'(delay_sel) > MAX_TAP) ? 8'(MAX_TAP) : delay_sel;
    tapped  = taps[0];
    for (int k = 1; k < DELAY_DEPTH; k++) begin
      if (tap_idx == 8'(k)) tapped = taps[k];
    end
  end

  assign eff_period  = (shp_q == '0) ? CNT_W'(1) : shp_q;
  assign period_last = eff_period - CNT_W'(1);
  assign pass_last   = eff_period - shl_q - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shp_d   = shp_q;
    shl_d   = shl_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (int_en) begin
          shp_d   = int_period;
          shl_d   = int_len;
          state_d = start_state(int_period, int_len);
        end
      end
      ST_PASS, ST_BLOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == period_last) begin
          // Wrap: new configuration is only picked up here
          cnt_d   = '0;
          shp_d   = int_period;
          shl_d   = int_len;
          state_d = start_state(int_period, int_len);
        end else if (state_q == ST_PASS && shl_q != '0 && cnt_q == pass_last) begin
          state_d = ST_BLOCK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!int_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign blocked = (state_q == ST_BLOCK) || channel_interrupt;

`ifdef CHANNEL_ERR_INJECT_EN
  logic [15:0] lfsr_val;

  channel_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (channel_clk),
    .rst_n  (channel_rst),
    .en     (1'b1),
    .load   (1'b0),
    .seed_i (LFSR_SEED),
    .lfsr_o (lfsr_val)
  );

  assign flip = !blocked && (lfsr_val < ber_thresh);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (flip && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end
`else
  logic unused_ber;
  assign unused_ber = ^ber_thresh;
  assign flip       = 1'b0;

  always_comb begin
    err_cnt_d = 16'd0;
  end
`endif

  always_comb begin
    data_o_d     = blocked ? IDLE_WORD : (tapped ^ {LANES{flip}});
    int_active_d = blocked;
  end

  always_ff @(posedge channel_clk or negedge channel_rst) begin
    if (!channel_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shp_q        <= '0;
      shl_q        <= '0;
      data_o_q     <= IDLE_WORD;
      int_active_q <= 1'b0;
      err_cnt_q    <= 16'd0;
      for (int k = 0; k < DL_N; k++) dl_q[k] <= IDLE_WORD;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shp_q        <= shp_d;
      shl_q        <= shl_d;
      data_o_q     <= data_o_d;
      int_active_q <= int_active_d;
      err_cnt_q    <= err_cnt_d;
      for (int k = 0; k < DL_N; k++) dl_q[k] <= dl_d[k];
    end
  end

  assign data_o     = data_o_q;
  assign int_active = int_active_q;
  assign err_count  = err_cnt_q;

endmodule

// File: doc/channel_emulator.md
CHANNEL_EMULATOR -- requirements
Module: channel_emulator

Interface
REQ-001 Parameter LANES, default 1: number of parallel 1-bit data lanes.
REQ-002 Parameter DELAY_DEPTH, default 16: delay-line length in cycles per lane (2..256).
REQ-003 Parameter CNT_W, default 20: width of interrupt period/length counters.
REQ-004 Parameter IDLE_LEVEL, default 1'b0: level driven on every lane while the channel is interrupted.
REQ-005 channel_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 channel_rst  input  1  reset, asynchronous, active-low.
REQ-007 data_i  input  LANES  transmitter line bits, sampled every cycle.
REQ-008 delay_sel  input  8  delay tap select; latency is delay_sel+1 cycles.
REQ-009 int_en  input  1  enables the periodic interrupt generator.
REQ-010 int_period  input  CNT_W  interrupt period in cycles.
REQ-011 int_len  input  CNT_W  interrupted cycles per period.
REQ-012 channel_interrupt  input  1  external forced interrupt, effective the same cycle it is sampled.
REQ-013 ber_thresh  input  16  bit-error threshold; 0 disables flips.
REQ-014 data_o  output  LANES  impaired line bits, registered.
REQ-015 int_active  output  1  high while data_o is forced to IDLE_LEVEL.
REQ-016 err_count  output  16  number of cycles with an injected flip, saturating.

Function
REQ-017 Delay line SHALL be a per-lane shift register of DELAY_DEPTH stages; data_o takes tap min(delay_sel, DELAY_DEPTH-1), so latency is min(delay_sel, DELAY_DEPTH-1)+1 cycles.
REQ-018 Interrupt FSM states: IDLE, PASS, BLOCK; period counter cnt (CNT_W bits).
REQ-019 IDLE: cnt=0; int_en=1 -> PASS next cycle, latching int_period/int_len into shadow registers.
REQ-020 PASS: cnt increments; when cnt == shadow_period-shadow_len-1 -> BLOCK.
REQ-021 BLOCK: cnt increments; at cnt == shadow_period-1, cnt wraps to 0, shadows reload, state -> PASS.
REQ-022 int_en=0 in any state -> IDLE next cycle, cnt cleared.
REQ-023 shadow_len=0 -> never BLOCK; shadow_len >= shadow_period -> BLOCK permanently until int_en=0; shadow_period=0 treated as 1.
REQ-024 Blocked = (state==BLOCK) OR channel_interrupt; when blocked, data_o = {LANES{IDLE_LEVEL}} and int_active=1 on the next edge; the delay line keeps shifting.
REQ-025 Config input changes mid-period SHALL take effect only at wrap or on IDLE exit.

Reset
REQ-026 On channel_rst low: state=IDLE, cnt=0, delay line cleared to IDLE_LEVEL, data_o={LANES{IDLE_LEVEL}}, int_active=0, err_count=0, LFSR=16'hACE1.
REQ-027 Reset mid-period SHALL discard shadows; the first cycle after release behaves as IDLE.

Configuration
REQ-028 Macro CHANNEL_ERR_INJECT_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; on a non-blocked cycle with lfsr < ber_thresh, all lanes of data_o are inverted and err_count increments, saturating at 16'hFFFF.
REQ-029 Macro undefined: no LFSR, ber_thresh ignored, err_count tied to 0.

Structure
REQ-030 Shared package channel_pkg holds the FSM state enum, LFSR seed 16'hACE1, and tap constant.
REQ-031 One sub-module, channel_lfsr (seedable 16-bit LFSR with enable), instantiated only under CHANNEL_ERR_INJECT_EN.

Verification
REQ-032 delay_sel=5, int_en=0, ber_thresh=0, data_i pulse at cycle 10 -> data_o pulse at cycle 16; delay_sel=40 with DELAY_DEPTH=16 -> latency 16.
REQ-033 int_en=1, int_period=150, int_len=120 -> int_active low for 30 cycles then high for 120, repeating; data_o=IDLE_LEVEL while high.
REQ-034 int_period changed to 10 mid-period -> old 150-cycle period completes, new period starts at wrap.
REQ-035 int_len=0 with channel_interrupt pulsed 3 cycles -> int_active high for exactly 3 cycles, one cycle after the pulse.
REQ-036 CHANNEL_ERR_INJECT_EN, ber_thresh=16'hFFFF, int_en=0 -> every data_o bit inverted relative to delayed data_i, err_count increments each cycle; ber_thresh=0 -> no flips.
REQ-037 channel_rst low during BLOCK -> outputs reset asynchronously; after release, IDLE with cnt=0 and int_active=0.
